apb_req_arbiter: RTL and testbench

- Two-requester arbiter in front of the single APB manager in the MCU.
- Lets the RV32I core (requester 0) and a second bus master (requester 1, e.g. a DMA or debug loader) share the RAM/GPO APB fabric.
- Each requester uses the same transfer/ready command interface the core already drives.
- Output is one registered command stream toward the APB manager, with round-robin fairness and one outstanding transfer at a time.

---
 rtl/apb_req_arbiter.sv | 138 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter feeding one registered command stream to the APB manager.
// Optional WAIT-state timeout with forced completion is built when BUS_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              m0_transfer,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_strb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,

    input  logic              m1_transfer,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_strb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,

    output logic              s_transfer,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [2:0]        s_strb,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,

    output logic [1:0]        grant
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic              s_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   last_grant;   // index of the requester served most recently
    logic   req_any;
    logic   pick_m1;
    logic   launch;
    logic   done;
    logic   timeout_hit;
    logic [DATA_W-1:0] rdata_sel;

    // Round robin: a lone requester always wins; on a tie the one not served last wins.
    assign req_any = m0_transfer | m1_transfer;
    assign pick_m1 = m1_transfer & (~m0_transfer | ~last_grant);
    assign launch  = (state == IDLE) & req_any;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts completed WAIT cycles; cleared while in ISSUE so it starts at zero on WAIT entry.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT) & ~s_ready & (wait_cnt == CNT_W'(TIMEOUT_CYC));
    assign s_timeout   = timeout_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    // s_ready only counts in WAIT; in IDLE and ISSUE it is deliberately ignored.
    assign done = (state == WAIT) & (s_ready | timeout_hit);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            s_transfer <= 1'b0;
            s_write    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_strb     <= '0;
            grant      <= 2'b00;
        end else begin
            state      <= state_nxt;
            s_transfer <= launch;
            if (launch) begin
                s_write <= pick_m1 ? m1_write : m0_write;
                s_addr  <= pick_m1 ? m1_addr  : m0_addr;
                s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                s_strb  <= pick_m1 ? m1_strb  : m0_strb;
                grant   <= pick_m1 ? 2'b10 : 2'b01;
            end
            if (done) begin
                last_grant <= grant[1];
                grant      <= 2'b00;
            end
        end
    end

    // Completion is combinational so the requester sees ready in the same cycle as s_ready.
    assign rdata_sel = timeout_hit ? DATA_W'(32'hDEAD_BEEF) : s_rdata;
    assign m0_ready  = done & grant[0];
    assign m1_ready  = done & grant[1];
    assign m0_rdata  = m0_ready ? rdata_sel : '0;
    assign m1_rdata  = m1_ready ? rdata_sel : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration model. Define BUS_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_apb_req_arbiter;

    typedef struct {
        bit          act;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  strb;
    } cmd_t;

    logic        PCLK;
    logic        PRESET;
    logic        m0_transfer, m0_write, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_strb;
    logic        m1_transfer, m1_write, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_strb;
    logic        s_transfer, s_write, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_strb;
    logic [1:0]  grant;
`ifdef BUS_ARB_TIMEOUT_EN
    logic        s_timeout;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   exp_last = 1;   // model: requester served most recently
    cmd_t req [2];

    apb_req_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_strb(m0_strb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_strb(m1_strb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_transfer(s_transfer), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_strb(s_strb), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .s_timeout(s_timeout)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.act   = 1'b1;
        c.wr    = 1'($urandom_range(1));
        c.addr  = $urandom;
        c.wdata = $urandom;
        c.strb  = 3'($urandom_range(7));
        return c;
    endfunction

    function automatic cmd_t m1_read();
        cmd_t c;
        c.act   = 1'b1;
        c.wr    = 1'b0;
        c.addr  = 32'h1000_0000;
        c.wdata = $urandom;
        c.strb  = 3'b010;
        return c;
    endfunction

    // Arbitration rule: single requester wins; on a tie the one not served last wins.
    function automatic int pick(input bit a0, input bit a1);
        if (a0 && a1) return 1 - exp_last;
        if (a1) return 1;
        return 0;
    endfunction

    function automatic logic rdy(input int i);
        return (i == 1) ? m1_ready : m0_ready;
    endfunction

    function automatic logic [31:0] rdat(input int i);
        return (i == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic apply();
        m0_transfer = req[0].act; m0_write = req[0].wr; m0_addr = req[0].addr;
        m0_wdata = req[0].wdata;  m0_strb = req[0].strb;
        m1_transfer = req[1].act; m1_write = req[1].wr; m1_addr = req[1].addr;
        m1_wdata = req[1].wdata;  m1_strb = req[1].strb;
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // Starts in IDLE with requests applied; returns at the negedge of the completing WAIT cycle.
    task automatic txn(input int lat, input bit issue_rdy, input bit drop, input logic [31:0] rd,
                       output int owner);
        cmd_t        ec;
        logic [1:0]  eg;
        owner = pick(req[0].act, req[1].act);
        ec    = req[owner];
        eg    = (owner == 1) ? 2'b10 : 2'b01;
        step();
        s_ready = issue_rdy;
        s_rdata = $urandom;
        #1;
        check("issue_s_transfer", 32'(s_transfer), 32'd1);
        check("issue_grant", 32'(grant), 32'(eg));
        check("issue_s_write", 32'(s_write), 32'(ec.wr));
        check("issue_s_addr", s_addr, ec.addr);
        check("issue_s_wdata", s_wdata, ec.wdata);
        check("issue_s_strb", 32'(s_strb), 32'(ec.strb));
        check("issue_m0_ready", 32'(m0_ready), 32'd0);
        check("issue_m1_ready", 32'(m1_ready), 32'd0);
        if (drop) begin
            req[owner].act = 1'b0;
            apply();
        end
        for (int i = 0; i < lat; i++) begin
            step();
            s_ready = 1'b0;
            #1;
            check("wait_s_transfer", 32'(s_transfer), 32'd0);
            check("wait_grant", 32'(grant), 32'(eg));
            check("wait_s_addr", s_addr, ec.addr);
            check("wait_s_wdata", s_wdata, ec.wdata);
            check("wait_m0_ready", 32'(m0_ready), 32'd0);
            check("wait_m1_ready", 32'(m1_ready), 32'd0);
        end
        step();
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        check("done_own_ready", 32'(rdy(owner)), 32'd1);
        check("done_other_ready", 32'(rdy(1 - owner)), 32'd0);
        check("done_own_rdata", rdat(owner), rd);
        check("done_other_rdata", rdat(1 - owner), 32'd0);
        check("done_grant", 32'(grant), 32'(eg));
        exp_last = owner;
    endtask

    // Apply post-completion commands, move into IDLE with s_ready still high (must be ignored).
    task automatic to_idle();
        apply();
        step();
        #1;
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_s_transfer", 32'(s_transfer), 32'd0);
        check("idle_m0_ready", 32'(m0_ready), 32'd0);
        check("idle_m1_ready", 32'(m1_ready), 32'd0);
        check("idle_m0_rdata", m0_rdata, 32'd0);
        check("idle_m1_rdata", m1_rdata, 32'd0);
        s_ready = 1'b0;
    endtask

    initial begin
        int owner;
        PRESET  = 1'b0;
        s_ready = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            req[i]     = rand_cmd();
            req[i].act = 1'b0;
        end
        apply();
        #12;
        check("rst_s_transfer", 32'(s_transfer), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_write", 32'(s_write), 32'd0);
        check("rst_s_strb", 32'(s_strb), 32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
`ifdef BUS_ARB_TIMEOUT_EN
        check("rst_s_timeout", 32'(s_timeout), 32'd0);
`endif
        step();
        PRESET = 1'b1;

        // m0 write, manager ready two cycles after s_transfer.
        req[0].act = 1'b1; req[0].wr = 1'b1; req[0].addr = 32'h1000_0004;
        req[0].wdata = 32'h0000_000A; req[0].strb = 3'b010;
        apply();
        txn(1, 1'b0, 1'b0, 32'h0BAD_F00D, owner);
        check("t1_owner_m0_ready_seen", 32'(owner), 32'd0);
        req[0].act = 1'b0;
        to_idle();

        // Reset asserted mid-WAIT abandons the transfer; everything clears immediately.
        req[1] = rand_cmd();
        apply();
        step();
        step();
        #2;
        PRESET = 1'b0;
        #1;
        check("midrst_s_transfer", 32'(s_transfer), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_s_addr", s_addr, 32'd0);
        check("midrst_s_wdata", s_wdata, 32'd0);
        check("midrst_s_write", 32'(s_write), 32'd0);
        check("midrst_s_strb", 32'(s_strb), 32'd0);
        check("midrst_m1_ready", 32'(m1_ready), 32'd0);
        check("midrst_m1_rdata", m1_rdata, 32'd0);
        exp_last   = 1;
        req[1].act = 1'b0;
        apply();
        step();
        PRESET = 1'b1;

        // Both request in the same IDLE cycle after reset: m0 first, then m1.
        req[0] = rand_cmd();
        req[1] = rand_cmd();
        apply();
        txn(2, 1'b1, 1'b0, $urandom, owner);
        req[0].act = 1'b0;
        to_idle();
        txn(1, 1'b0, 1'b0, $urandom, owner);
        req[1].act = 1'b0;
        to_idle();

        // Both held for six transfers: grants alternate starting with m0; m1 reads 0x1000_0000.
        req[0] = rand_cmd();
        req[1] = m1_read();
        apply();
        for (int i = 0; i < 6; i++) begin
            txn(1 + (i % 2), 1'b0, 1'b0, 32'h1234_5678, owner);
            if (owner == 0) req[0] = rand_cmd();
            else            req[1] = m1_read();
            to_idle();
        end
        req[0].act = 1'b0;
        req[1].act = 1'b0;
        apply();
        step();

        // m1 withdraws during WAIT of its granted read; the transfer still completes once.
        req[1] = m1_read();
        apply();
        txn(2, 1'b0, 1'b1, 32'hCAFE_0001, owner);
        to_idle();
        step();
        #1;
        check("drop_m1_ready_once", 32'(m1_ready), 32'd0);
        check("drop_state_idle_grant", 32'(grant), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i].act && $urandom_range(1) == 1) req[i] = rand_cmd();
                else if (req[i].act && $urandom_range(3) == 0) req[i].act = 1'b0;
            end
            if (!req[0].act && !req[1].act && $urandom_range(3) != 0)
                req[$urandom_range(1)] = rand_cmd();
            apply();
            if (!req[0].act && !req[1].act) begin
                step();
                #1;
                check("rand_idle_grant", 32'(grant), 32'd0);
                check("rand_idle_s_transfer", 32'(s_transfer), 32'd0);
                continue;
            end
            txn($urandom_range(3), 1'($urandom_range(1)), ($urandom_range(3) == 0),
                $urandom, owner);
            if ($urandom_range(1) == 1) req[owner] = rand_cmd();
            else                        req[owner].act = 1'b0;
            to_idle();
        end
        req[0].act = 1'b0;
        req[1].act = 1'b0;
        apply();
        step();

`ifdef BUS_ARB_TIMEOUT_EN
        // Manager never answers: after 8 WAIT cycles the arbiter forces completion.
        exp_last = 1;
        req[0] = rand_cmd();
        apply();
        step();
        s_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            check("to_wait_m0_ready", 32'(m0_ready), 32'd0);
            check("to_wait_s_timeout", 32'(s_timeout), 32'd0);
        end
        step();
        #1;
        check("to_m0_ready", 32'(m0_ready), 32'd1);
        check("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("to_s_timeout", 32'(s_timeout), 32'd1);
        check("to_m1_ready", 32'(m1_ready), 32'd0);
        req[0].act = 1'b0;
        apply();
        step();
        s_ready = 1'b1;
        #1;
        check("to_late_m0_ready", 32'(m0_ready), 32'd0);
        check("to_late_s_timeout", 32'(s_timeout), 32'd0);
        check("to_late_grant", 32'(grant), 32'd0);
        s_ready = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
